// File: rtl/mac_real_if.sv
// Stream bundle for mac_real: (a, b, in_last) input beats and a per-frame result.
// Payload widths are parameters and must match the mac_real instance they connect to.
interface mac_real_if #(
    parameter int unsigned a_width   = 18,
    parameter int unsigned b_width   = 18,
    parameter int unsigned out_width = 25
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [a_width-1:0]   a;
    logic signed [b_width-1:0]   b;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [out_width-1:0] out;
    logic                        out_sat;

    modport master (
        output in_valid, a, b, in_last, out_ready,
        input  in_ready, out_valid, out, out_sat
    );

    modport slave (
        input  in_valid, a, b, in_last, out_ready,
        output in_ready, out_valid, out, out_sat
    );
endinterface

// File: rtl/mac_real.sv
// Streaming fixed-point multiply-accumulate: sums a*b over a frame, then emits
// the sum re-aligned to the out exponent and saturated to out_width bits.
module mac_real #(
    parameter int unsigned a_width      = 18,
    parameter int          a_exponent   = -12,
    parameter int unsigned b_width      = 18,
    parameter int          b_exponent   = -12,
    parameter int unsigned out_width    = 25,
    parameter int          out_exponent = -16,
    parameter int unsigned acc_width    = 48
) (
    input  logic         clk,
    input  logic         rst,
    mac_real_if.slave    bus
);
    localparam int unsigned prod_width = a_width + b_width;
    localparam int          shift      = a_exponent + b_exponent - out_exponent;
    localparam int unsigned sh_l       = (shift > 0) ? unsigned'(shift)  : 32'd0;
    localparam int unsigned sh_r       = (shift < 0) ? unsigned'(-shift) : 32'd0;
    localparam int unsigned ext_width  = acc_width + sh_l;
    localparam int unsigned cw         = (ext_width > out_width) ? ext_width : out_width;

    localparam logic signed [cw-1:0] sat_hi =
        {{(cw - out_width + 1){1'b0}}, {(out_width - 1){1'b1}}};
    localparam logic signed [cw-1:0] sat_lo =
        {{(cw - out_width + 1){1'b1}}, {(out_width - 1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   load_out;
    logic   release_out;

    logic                         v1, l1, v2, l2;
    logic signed [prod_width-1:0] p1;
    logic signed [acc_width-1:0]  acc;

    logic signed [cw-1:0]         conv;
    logic signed [out_width-1:0]  conv_out;
    logic                         conv_sat;

    // in_ready depends only on state and reset
    assign bus.in_ready = (state == ACCUM) && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = bus.in_valid && bus.in_ready;
        load_out    = 1'b0;
        release_out = 1'b0;
        case (state)
            ACCUM: if (accept && bus.in_last) state_nxt = DRAIN;
            DRAIN: if (v2 && l2) begin
                load_out  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: if (bus.out_ready) begin
                release_out = 1'b1;
                state_nxt   = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Re-align the accumulator to the out exponent, then clip to out_width
    always_comb begin
        conv     = cw'(acc);
        conv     = conv <<< sh_l;
        conv     = conv >>> sh_r;
        conv_sat = 1'b0;
        conv_out = out_width'(conv);
        if (conv > sat_hi) begin
            conv_out = out_width'(sat_hi);
            conv_sat = 1'b1;
        end else if (conv < sat_lo) begin
            conv_out = out_width'(sat_lo);
            conv_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1            <= 1'b0;
            l1            <= 1'b0;
            p1            <= '0;
            v2            <= 1'b0;
            l2            <= 1'b0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.out_sat   <= 1'b0;
        end else begin
            v1 <= accept;
            l1 <= accept && bus.in_last;
            if (accept) p1 <= prod_width'(bus.a) * prod_width'(bus.b);
            v2 <= v1;
            l2 <= l1;
            // Clearing on result load keeps frames from bleeding into each other
            if (load_out)  acc <= '0;
            else if (v1)   acc <= acc + acc_width'(p1);
            if (load_out) begin
                bus.out       <= conv_out;
                bus.out_sat   <= conv_sat;
                bus.out_valid <= 1'b1;
            end else if (release_out) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_real.sv
// Directed bench for mac_real: scoreboard of expected frame results, checked
// with immediate assertions as each result appears.
module tb_mac_real;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_real_if #(.a_width(18), .b_width(18), .out_width(25)) bus();

    mac_real #(
        .a_width(18), .a_exponent(-12), .b_width(18), .b_exponent(-12),
        .out_width(25), .out_exponent(-16), .acc_width(48)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic signed [24:0] o;
        logic               s;
    } exp_t;

    exp_t   sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    int     acc_cyc = 0;
    longint fsum  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // Reference: sum is in 2^-24 units, out is 2^-16 units -> floor shift by 8
    function automatic exp_t model(input longint s);
        exp_t   e;
        longint v;
        v = s >>> 8;
        e.s = 1'b0;
        if (v > 64'sd16777215) begin
            e.o = 25'sd16777215;
            e.s = 1'b1;
        end else if (v < -64'sd16777216) begin
            e.o = -25'sd16777216;
            e.s = 1'b1;
        end else begin
            e.o = 25'(v);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Starts and ends at a negedge; leaves in_valid low afterwards
    task automatic send(input int av, input int bv, input bit last);
        int k;
        bus.a        = 18'(av);
        bus.b        = 18'(bv);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
            acc_cyc = cyc;
            fsum += longint'(av) * longint'(bv);
            if (last) begin
                sb.push_back(model(fsum));
                fsum = 0;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic get_result(input int stall, input bit chk_lat, input string tag);
        int   k;
        exp_t e;
        logic signed [24:0] o0;
        logic               s0;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        if (bus.out_valid !== 1'b1) return;
        if (chk_lat) chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd2);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_out"}, 64'(bus.out), 64'(e.o));
        chk({tag, "_sat"}, 64'(bus.out_sat), 64'(e.s));
        o0 = bus.out;
        s0 = bus.out_sat;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold_out"}, 64'(bus.out), 64'(o0));
            chk({tag, "_hold_sat"}, 64'(bus.out_sat), 64'(s0));
            chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_released"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out", 64'(bus.out), 64'd0);
        chk("rst_out_sat", 64'(bus.out_sat), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Basic three-beat frame: 1.5*2 - 0.5*1 + 0.25*4 = 3.5
        send(6144, 8192, 1'b0);
        send(-2048, 4096, 1'b0);
        send(1024, 16384, 1'b1);
        chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
        get_result(0, 1'b1, "basic");

        // Single-beat frame, independent of the previous one
        send(6144, 8192, 1'b1);
        get_result(0, 1'b1, "single");

        send(131071, 131071, 1'b1);
        get_result(0, 1'b1, "sat_pos");
        send(-131072, 131071, 1'b1);
        get_result(0, 1'b1, "sat_neg");

        // Output backpressure for 5 cycles
        send(1024, 16384, 1'b1);
        get_result(5, 1'b1, "backpressure");

        // Bubbles within a frame; tiny sums truncate toward minus infinity
        send(1, 1, 1'b0);
        repeat (3) @(negedge clk);
        send(1, 1, 1'b1);
        get_result(0, 1'b1, "bubble_trunc");
        send(-1, 1, 1'b1);
        get_result(0, 1'b1, "neg_trunc");

        // Reset mid-frame discards the partial frame
        send(6144, 8192, 1'b0);
        send(-2048, 4096, 1'b0);
        rst  = 1'b1;
        fsum = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_valid", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
        end
        send(6144, 8192, 1'b1);
        get_result(2, 1'b1, "after_rst");

        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
